// File: rtl/stb_dcache_drain_pkg.sv
// Shared dcache geometry and the drain FSM state type.
package cache_defs;
  localparam int unsigned DCACHE_ADDR_WIDTH = 32;
  localparam int unsigned DCACHE_DATA_WIDTH = 32;
  localparam int unsigned BLEN              = DCACHE_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WAIT = 2'd1,
    LD_WAIT = 2'd2
  } drain_state_e;
endpackage

// File: rtl/stb_dcache_drain_if.sv
// Single dcache request/ack port shared between store drain and LSU loads.
interface stb_dcache_drain_if;
  import cache_defs::*;

  logic                         dc_req;
  logic                         dc_we;
  logic [DCACHE_ADDR_WIDTH-1:0] dc_addr;
  logic [DCACHE_DATA_WIDTH-1:0] dc_wdata;
  logic [BLEN-1:0]              dc_sel_byte;
  logic                         dc_ack;
  logic [DCACHE_DATA_WIDTH-1:0] dc_rdata;

  modport master (
    output dc_req, dc_we, dc_addr, dc_wdata, dc_sel_byte,
    input  dc_ack, dc_rdata
  );

  modport slave (
    input  dc_req, dc_we, dc_addr, dc_wdata, dc_sel_byte,
    output dc_ack, dc_rdata
  );
endinterface

// File: rtl/stb_dcache_drain.sv
// Drains committed stores from the store buffer into the dcache, arbitrating
// the shared port against LSU loads with a bounded load-starvation window.
module stb_dcache_drain
  import cache_defs::*;
#(
  parameter int unsigned LD_STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stb_empty,
  input  logic                         stb_full,
  input  logic [DCACHE_ADDR_WIDTH-1:0] stb_addr,
  input  logic [DCACHE_DATA_WIDTH-1:0] stb_wdata,
  input  logic [BLEN-1:0]              stb_sel_byte,
  output logic                         stb_rd_sel,
  output logic                         stb_rd_en,
  input  logic                         lsu_ld_req,
  input  logic [DCACHE_ADDR_WIDTH-1:0] lsu_ld_addr,
  output logic                         lsu_ld_ack,
  output logic [DCACHE_DATA_WIDTH-1:0] lsu_ld_rdata,
  input  logic                         fence_req,
  output logic                         fence_done,
  stb_dcache_drain_if.master           dc
);

  localparam int unsigned CW = $clog2(LD_STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LD_STARVE_MAX);

  drain_state_e                 state, state_nxt;
  logic [CW-1:0]                starve_cnt;
  logic                         fence_pend;
  logic [DCACHE_ADDR_WIDTH-1:0] ld_addr_q;
  logic                         force_st;
  logic                         grant_st;
  logic                         grant_ld;

  always_comb begin
    state_nxt    = state;
    grant_st     = 1'b0;
    grant_ld     = 1'b0;
    force_st     = fence_pend | stb_full | (starve_cnt == CNT_MAX);
    stb_rd_sel   = 1'b0;
    stb_rd_en    = 1'b0;
    lsu_ld_ack   = 1'b0;
    lsu_ld_rdata = '0;
    fence_done   = fence_pend & stb_empty & (state == IDLE);
    dc.dc_req      = 1'b0;
    dc.dc_we       = 1'b0;
    dc.dc_addr     = '0;
    dc.dc_wdata    = '0;
    dc.dc_sel_byte = '0;

    unique case (state)
      IDLE: begin
        // A pending fence blocks loads even once the buffer is empty.
        if (force_st && !stb_empty) begin
          grant_st  = 1'b1;
          state_nxt = ST_WAIT;
        end else if (lsu_ld_req && !fence_pend) begin
          grant_ld  = 1'b1;
          state_nxt = LD_WAIT;
        end else if (!stb_empty) begin
          grant_st  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stb_rd_sel     = 1'b1;
        dc.dc_req      = 1'b1;
        dc.dc_we       = 1'b1;
        dc.dc_addr     = stb_addr;
        dc.dc_wdata    = stb_wdata;
        dc.dc_sel_byte = stb_sel_byte;
        if (dc.dc_ack) begin
          stb_rd_en = 1'b1;
          state_nxt = IDLE;
        end
      end
      LD_WAIT: begin
        dc.dc_req      = 1'b1;
        dc.dc_addr     = ld_addr_q;
        dc.dc_sel_byte = '1;
        if (dc.dc_ack) begin
          lsu_ld_ack   = 1'b1;
          lsu_ld_rdata = dc.dc_rdata;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             starve_cnt <= '0;
    else if (stb_empty || grant_st)         starve_cnt <= '0;
    else if (grant_ld && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          fence_pend <= 1'b0;
    else if (fence_done) fence_pend <= 1'b0;
    else if (fence_req)  fence_pend <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ld_addr_q <= '0;
    else if (grant_ld) ld_addr_q <= lsu_ld_addr;
  end

  a_ld_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state == LD_WAIT) |-> lsu_ld_req);
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (dc.dc_req && !dc.dc_ack) |=> dc.dc_req);
  a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    stb_rd_en |-> !stb_empty);

endmodule

// File: tb/tb_stb_dcache_drain.sv
// Bench for stb_dcache_drain: directed cycle table, then randomized traffic
// against a transaction-level model of the STB, LSU and dcache.
module tb_stb_dcache_drain;
  import cache_defs::*;

  localparam int unsigned SMAX  = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb_empty, stb_full;
  logic [31:0] stb_addr, stb_wdata;
  logic [3:0]  stb_sel_byte;
  logic        stb_rd_sel, stb_rd_en;
  logic        lsu_ld_req;
  logic [31:0] lsu_ld_addr;
  logic        lsu_ld_ack;
  logic [31:0] lsu_ld_rdata;
  logic        fence_req, fence_done;

  stb_dcache_drain_if dc();

  stb_dcache_drain #(.LD_STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .stb_empty(stb_empty), .stb_full(stb_full),
    .stb_addr(stb_addr), .stb_wdata(stb_wdata), .stb_sel_byte(stb_sel_byte),
    .stb_rd_sel(stb_rd_sel), .stb_rd_en(stb_rd_en),
    .lsu_ld_req(lsu_ld_req), .lsu_ld_addr(lsu_ld_addr),
    .lsu_ld_ack(lsu_ld_ack), .lsu_ld_rdata(lsu_ld_rdata),
    .fence_req(fence_req), .fence_done(fence_done),
    .dc(dc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {dc.dc_req, dc.dc_we, dc.dc_addr, dc.dc_wdata, dc.dc_sel_byte, stb_rd_sel,
             stb_rd_en, lsu_ld_ack, lsu_ld_rdata, fence_done}, '0);
  endtask

  // Directed table: inputs {empty, full, ld_req, fence_req, dc_ack},
  // expected {dc_req, dc_we, stb_rd_en, lsu_ld_ack, fence_done}.
  typedef struct packed { logic [4:0] i; logic [4:0] o; } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [4:0] i, input logic [4:0] o);
    tbl.push_back(vec_t'({i, o}));
  endtask

  // Transaction-level environment state.
  typedef struct packed { logic [31:0] a; logic [31:0] d; logic [3:0] s; } ent_t;
  ent_t        q[$];
  logic [31:0] mmem[16];
  logic [31:0] smem[16];
  bit          busy, kst, fpend, ldp, fr_now, rnd;
  int unsigned mcnt, lat, wcnt;
  logic [31:0] lda, last_pop_a;
  int          n_st, n_ld, n_fd;

  task automatic model_reset();
    busy = 0; kst = 0; fpend = 0; mcnt = 0; wcnt = 0; fr_now = 0;
  endtask

  task automatic push_ent();
    ent_t e;
    e.a = 32'($urandom_range(15)) << 2;
    e.d = $urandom;
    e.s = 4'($urandom_range(1, 15));
    q.push_back(e);
  endtask

  // One clock of the randomized environment; entered and left at posedge+1.
  task automatic env_cycle();
    bit          e_now, exp_rden, exp_ldack, exp_fd, frc;
    logic [67:0] exp_bus;
    int unsigned ix;
    e_now        = (q.size() == 0);
    stb_empty    = e_now;
    stb_full     = (q.size() >= DEPTH);
    stb_addr     = e_now ? $urandom : q[0].a;
    stb_wdata    = e_now ? $urandom : q[0].d;
    stb_sel_byte = e_now ? 4'($urandom) : q[0].s;
    lsu_ld_req   = ldp;
    lsu_ld_addr  = ldp ? lda : $urandom;
    fence_req    = fr_now;
    dc.dc_ack    = dc.dc_req ? (wcnt >= lat) : (rnd && $urandom_range(9) == 0);
    dc.dc_rdata  = (dc.dc_req && dc.dc_ack && !dc.dc_we) ? smem[dc.dc_addr[5:2]] : $urandom;

    @(negedge clk);
    exp_rden  = busy && kst && dc.dc_ack;
    exp_ldack = busy && !kst && dc.dc_ack;
    exp_fd    = fpend && e_now && !busy;
    if (busy && kst)  exp_bus = {q[0].a, q[0].d, q[0].s};
    else if (busy)    exp_bus = {lda, 32'h0, 4'hF};
    else              exp_bus = '0;
    chk("rnd ctl", {dc.dc_req, dc.dc_we, stb_rd_sel, stb_rd_en, lsu_ld_ack, fence_done},
        {busy, busy && kst, busy && kst, exp_rden, exp_ldack, exp_fd});
    chk("rnd bus", {dc.dc_addr, dc.dc_wdata, dc.dc_sel_byte}, exp_bus);
    chk("rnd rdata", lsu_ld_rdata, exp_ldack ? mmem[lda[5:2]] : 32'h0);
    if (stb_rd_en)  begin n_st++; last_pop_a = dc.dc_addr; end
    if (lsu_ld_ack) n_ld++;
    if (fence_done) n_fd++;

    if (dc.dc_req) begin
      if (dc.dc_ack) begin
        if (dc.dc_we) begin
          ix = 32'(dc.dc_addr[5:2]);
          for (int b = 0; b < 4; b++)
            if (dc.dc_sel_byte[b]) smem[ix][8*b +: 8] = dc.dc_wdata[8*b +: 8];
        end
        wcnt = 0;
        lat  = $urandom_range(3);
      end else wcnt++;
    end

    if (busy) begin
      if (dc.dc_ack) begin
        busy = 0;
        if (kst) begin
          ix = 32'(q[0].a[5:2]);
          for (int b = 0; b < 4; b++)
            if (q[0].s[b]) mmem[ix][8*b +: 8] = q[0].d[8*b +: 8];
          void'(q.pop_front());
        end else ldp = 0;
      end
      if (e_now) mcnt = 0;
    end else begin
      frc = fpend || !stb_full ? (fpend || (mcnt == SMAX)) : 1'b1;
      if (frc && !e_now)          begin busy = 1; kst = 1; mcnt = 0; end
      else if (ldp && !fpend)     begin busy = 1; kst = 0;
                                        mcnt = e_now ? 0 : (mcnt == SMAX ? SMAX : mcnt + 1); end
      else if (!e_now)            begin busy = 1; kst = 1; mcnt = 0; end
      else                        mcnt = 0;
    end
    if (exp_fd)      fpend = 0;
    else if (fr_now) fpend = 1;

    fr_now = 0;
    if (rnd) begin
      if (q.size() < DEPTH && $urandom_range(2) == 0) push_ent();
      if (!ldp && $urandom_range(3) == 0) begin
        ldp = 1;
        lda = 32'($urandom_range(15)) << 2;
      end
      fr_now = ($urandom_range(24) == 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk_all_zero("reset outs");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : main
    logic [67:0] exp_bus;
    logic        req, we;
    bit          ok;
    logic [31:0] head_a;

    stb_empty = 1; stb_full = 0; stb_addr = '0; stb_wdata = '0; stb_sel_byte = '0;
    lsu_ld_req = 0; lsu_ld_addr = '0; fence_req = 0;
    dc.dc_ack = 0; dc.dc_rdata = '0;
    #2 chk_all_zero("reset state");
    @(posedge clk); #1;
    rst_n = 1'b1;

    add(5'b10010, 5'b00000);  // empty fence
    add(5'b10000, 5'b00001);
    add(5'b10000, 5'b00000);
    add(5'b00000, 5'b00000);  // store drain, ack 3 cycles after req
    add(5'b00000, 5'b11000);
    add(5'b00000, 5'b11000);
    add(5'b00000, 5'b11000);
    add(5'b00001, 5'b11100);
    add(5'b10000, 5'b00000);
    add(5'b00100, 5'b00000);  // load beats a non-forced store
    add(5'b00101, 5'b10010);
    add(5'b00000, 5'b00000);
    add(5'b00001, 5'b11100);
    add(5'b10000, 5'b00000);
    for (int k = 0; k < 4; k++) begin  // starvation: four loads then a forced store
      add(5'b00100, 5'b00000);
      add(5'b00101, 5'b10010);
    end
    add(5'b00100, 5'b00000);
    add(5'b00101, 5'b11100);
    add(5'b10100, 5'b00000);
    add(5'b10101, 5'b10010);
    add(5'b00100, 5'b00000);  // counter restarted: load granted again
    add(5'b00101, 5'b10010);
    add(5'b00000, 5'b00000);
    add(5'b00001, 5'b11100);
    add(5'b10000, 5'b00000);
    add(5'b01100, 5'b00000);  // full forces store over a pending load
    add(5'b01101, 5'b11100);
    add(5'b10100, 5'b00000);
    add(5'b10101, 5'b10010);
    add(5'b00001, 5'b00000);  // ack in IDLE ignored
    add(5'b00000, 5'b11000);
    add(5'b00001, 5'b11100);
    add(5'b10000, 5'b00000);

    stb_addr = 32'h8000_0010; stb_wdata = 32'hDEAD_BEEF; stb_sel_byte = 4'b0011;
    lsu_ld_addr = 32'h100; dc.dc_rdata = 32'h1234_5678;
    for (int k = 0; k < tbl.size(); k++) begin
      {stb_empty, stb_full, lsu_ld_req, fence_req, dc.dc_ack} = tbl[k].i;
      @(negedge clk);
      req = tbl[k].o[4];
      we  = tbl[k].o[3];
      exp_bus = req ? (we ? {32'h8000_0010, 32'hDEAD_BEEF, 4'b0011} : {32'h100, 32'h0, 4'hF}) : '0;
      chk($sformatf("tbl%0d ctl", k), {dc.dc_req, dc.dc_we, stb_rd_en, lsu_ld_ack, fence_done}, tbl[k].o);
      chk($sformatf("tbl%0d bus", k), {dc.dc_addr, dc.dc_wdata, dc.dc_sel_byte}, exp_bus);
      chk($sformatf("tbl%0d misc", k), {stb_rd_sel, lsu_ld_rdata},
          {req & we, tbl[k].o[1] ? 32'h1234_5678 : 32'h0});
      @(posedge clk); #1;
    end
    fence_req = 0; dc.dc_ack = 0; lsu_ld_req = 0; stb_empty = 1;

    for (int i = 0; i < 16; i++) begin
      mmem[i] = $urandom;
      smem[i] = mmem[i];
    end
    ldp = 0; lat = 1; n_st = 0; n_ld = 0; n_fd = 0;
    do_reset();

    rnd = 1;
    repeat (3000) env_cycle();
    rnd = 0;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      env_cycle();
      ok = (q.size() == 0) && !ldp && !busy && !fpend;
    end
    chk("random drain", ok, 1'b1);

    // Full buffer with a pending load: store must go first.
    for (int i = 0; i < DEPTH; i++) push_ent();
    ldp = 1; lda = 32'h20; lat = 1;
    ok = 0;
    for (int c = 0; c < 5 && !ok; c++) begin
      env_cycle();
      ok = dc.dc_req;
    end
    chk("full first grant is store", {ok, dc.dc_we}, 2'b11);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      env_cycle();
      ok = (q.size() == 0) && !ldp && !busy;
    end
    chk("full drain", ok, 1'b1);

    // Fence with 3 entries while loads keep requesting.
    for (int i = 0; i < 3; i++) push_ent();
    fr_now = 1;
    n_st = 0; n_ld = 0; n_fd = 0;
    env_cycle();
    ldp = 1; lda = 32'h24;
    for (int c = 0; c < 60 && n_fd == 0; c++) env_cycle();
    chk("fence stores", n_st, 3);
    chk("fence loads", n_ld, 0);
    chk("fence done", n_fd, 1);
    for (int c = 0; c < 10 && n_ld == 0; c++) env_cycle();
    chk("load after fence", n_ld, 1);
    chk("fence single pulse", n_fd, 1);

    // Reset while a store waits for its ack.
    push_ent();
    head_a = q[0].a;
    lat = 10; wcnt = 0; n_st = 0;
    ok = 0;
    for (int c = 0; c < 5 && !ok; c++) begin
      env_cycle();
      ok = dc.dc_req && dc.dc_we;
    end
    chk("store before reset", ok, 1'b1);
    env_cycle();
    dc.dc_ack = 0;
    rst_n = 1'b0;
    #1 chk_all_zero("async reset outs");
    @(negedge clk);
    chk("no pop in reset", {stb_rd_en, dc.dc_req}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    lat = 1;
    chk("entry kept", {n_st, 32'(q.size())}, {32'd0, 32'd1});
    for (int c = 0; c < 20 && n_st == 0; c++) env_cycle();
    chk("reissue pop count", n_st, 1);
    chk("reissue head addr", last_pop_a, head_a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
